// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack port and
// buffers {pc, inst} pairs in a small FIFO that feeds ID over valid/ready.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_imem_req;
    logic [31:0]   r_imem_addr;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];

    logic [31:0]   w_target;
    logic          w_ack;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic          w_space;
    logic          w_load_addr;
    logic [31:0]   w_addr_next;
    logic [31:0]   w_fetch_pc_next;

    assign w_target = {redirect_pc[31:2], 2'b00};
    // An ack with no request outstanding is meaningless and ignored.
    assign w_ack    = imem_ack & r_imem_req;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_imem_req <= (w_state_next != IDLE);
        end
    end

    // NOTE: defaulting every comb output first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_space) w_state_next = BUSY;
            BUSY: begin
                if (w_ack)               w_state_next = w_space ? BUSY : IDLE;
                else if (redirect_valid) w_state_next = DROP;
            end
            DROP:    if (w_ack) w_state_next = BUSY;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_flush      = redirect_valid;
        w_push       = (r_state == BUSY) && w_ack && !redirect_valid;
        w_pop        = (r_count != '0) && inst_ready && !redirect_valid;
        w_count_next = w_flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
        w_space      = (w_count_next < DEPTH_C);
        // A new address is launched on every accepted response and on leaving IDLE.
        w_load_addr  = w_ack || ((r_state == IDLE) && (w_state_next == BUSY));
        if (redirect_valid)      w_addr_next = w_target;
        else if (r_state == BUSY) w_addr_next = r_fetch_pc + 32'd4;
        else                      w_addr_next = r_fetch_pc;
        if (redirect_valid) w_fetch_pc_next = w_target;
        else if (w_push)    w_fetch_pc_next = r_fetch_pc + 32'd4;
        else                w_fetch_pc_next = r_fetch_pc;
        imem_req   = r_imem_req;
        imem_addr  = r_imem_addr;
        inst_valid = (r_count != '0);
        inst       = r_fifo_inst[r_rd_ptr];
        inst_pc    = r_fifo_pc[r_rd_ptr];
    end

    // NOTE: the buffer is only a few entries, so it is reset to give inst/inst_pc a clean 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_inst[i] <= 32'h0;
                r_fifo_pc[i]   <= 32'h0;
            end
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;
            if (w_load_addr) r_imem_addr <= w_addr_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_inst[r_wr_ptr] <= imem_rdata;
                    r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
                    r_wr_ptr              <= r_wr_ptr + PW'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a memory model with programmable wait states
// answers fetches; each step compares DUT outputs with hand-computed values.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int   checks = 0;
    int   errors = 0;
    int   mem_lat;
    int   wait_cnt;
    logic ack_force;

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory answers after mem_lat wait cycles; ack_force injects a stray ack.
    assign imem_ack   = ack_force | (imem_req && (wait_cnt >= mem_lat));
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (imem_req && imem_ack)  wait_cnt <= 0;
        else if (imem_req)              wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!inst_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, inst_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        inst_ready = 1'b1; mem_lat = 0; ack_force = 1'b0;

        // Reset values before any clock edge.
        #1;
        check("rst_req",   imem_req,   1'b0);
        check("rst_addr",  imem_addr,  32'h0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_inst",  inst,       32'h0);
        check("rst_pc",    inst_pc,    32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Zero-wait streaming.
        tick();
        check("s_req1",   imem_req,   1'b1);
        check("s_addr1",  imem_addr,  32'h0);
        check("s_valid1", inst_valid, 1'b0);
        tick();
        check("s_valid2", inst_valid, 1'b1);
        check("s_pc2",    inst_pc,    32'h0);
        check("s_inst2",  inst,       mem_word(32'h0));
        check("s_addr2",  imem_addr,  32'h4);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("s_pc",   inst_pc,   32'(4 * k));
            check("s_inst", inst,      mem_word(32'(4 * k)));
            check("s_addr", imem_addr, 32'(4 * (k + 1)));
        end

        // Backpressure fills the buffer, then drains without gaps.
        inst_ready = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick();
        check("bp_req",   imem_req,   1'b0);
        check("bp_addr",  imem_addr,  32'h8);
        check("bp_valid", inst_valid, 1'b1);
        check("bp_pc0",   inst_pc,    32'h0);
        inst_ready = 1'b1;
        tick();
        check("bp_pc4",   inst_pc,    32'h4);
        check("bp_req2",  imem_req,   1'b1);
        check("bp_addr2", imem_addr,  32'h8);
        tick();
        check("bp_pc8",   inst_pc,    32'h8);
        tick();
        check("bp_pcC",   inst_pc,    32'hC);

        // Redirect while full and idle.
        inst_ready = 1'b0;
        tick();
        check("fr_full", inst_valid, 1'b1);
        check("fr_req",  imem_req,   1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("fr_valid", inst_valid, 1'b0);
        check("fr_req2",  imem_req,   1'b1);
        check("fr_addr",  imem_addr,  32'h200);
        tick();
        check("fr_pc",    inst_pc,    32'h200);
        check("fr_addr2", imem_addr,  32'h204);

        // Redirect coincident with ack and pop.
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("ar_valid", inst_valid, 1'b0);
        check("ar_addr",  imem_addr,  32'h300);
        check("ar_req",   imem_req,   1'b1);
        tick();
        check("ar_pc",    inst_pc,    32'h300);
        check("ar_inst",  inst,       mem_word(32'h300));

        // Misaligned target, then wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check("ma_addr", imem_addr, 32'h100);
        tick();
        check("ma_pc",   inst_pc,   32'h100);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_pc0",   inst_pc,   32'hFFFF_FFFC);
        check("wr_addr1", imem_addr, 32'h0);
        tick();
        check("wr_pc1",   inst_pc,   32'h0);
        check("wr_addr2", imem_addr, 32'h4);

        // Slow memory with a redirect while 0x8 is pending.
        mem_lat = 2;
        do_reset();
        tick(); tick(); tick(); tick();
        check("sl_pc0",   inst_pc,   32'h0);
        check("sl_addr4", imem_addr, 32'h4);
        tick(); tick(); tick();
        check("sl_pc4",   inst_pc,   32'h4);
        check("sl_addr8", imem_addr, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("dr_valid", inst_valid, 1'b0);
        check("dr_addr",  imem_addr,  32'h8);
        check("dr_req",   imem_req,   1'b1);
        tick();
        check("dr_hold",  imem_addr,  32'h8);
        tick();
        check("dr_new",   imem_addr,  32'h100);
        check("dr_empty", inst_valid, 1'b0);
        wait_valid("dr_timeout", 10);
        check("dr_pc",    inst_pc,    32'h100);
        check("dr_inst",  inst,       mem_word(32'h100));

        // Asynchronous reset pulse between edges; a stray ack afterwards is ignored.
        mem_lat = 20; inst_ready = 1'b0;
        tick();
        check("ar_pre_valid", inst_valid, 1'b1);
        rst = 1'b1;
        #2;
        check("ap_req",   imem_req,   1'b0);
        check("ap_addr",  imem_addr,  32'h0);
        check("ap_valid", inst_valid, 1'b0);
        check("ap_inst",  inst,       32'h0);
        check("ap_pc",    inst_pc,    32'h0);
        #1;
        rst = 1'b0; ack_force = 1'b1; inst_ready = 1'b1; mem_lat = 0;
        tick();
        ack_force = 1'b0;
        check("la_valid", inst_valid, 1'b0);
        check("la_req",   imem_req,   1'b1);
        check("la_addr",  imem_addr,  32'h0);
        tick();
        check("la_pc",    inst_pc,    32'h0);
        check("la_inst",  inst,       mem_word(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
